// File: rtl/coin_pkg.sv
// coin_pkg: denominations, amount width, FSM state encoding and stock update helper
// shared by the change dispenser.
package coin_pkg;
    localparam int         AMT_W  = 8;
    localparam logic [7:0] COIN5  = 8'd5;
    localparam logic [7:0] COIN10 = 8'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Saturating refill; a refill and a dispense in the same cycle cancel out.
    function automatic logic [7:0] stock_next(input logic [7:0] s, input logic inc, input logic dec);
        return (inc && !dec) ? ((s == 8'hFF) ? s : s + 8'd1) :
               (dec && !inc) ? s - 8'd1 : s;
    endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: valid/ready change request channel.
interface change_dispenser_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_amount;

    modport master (output req_valid, output req_amount, input req_ready);
    modport slave  (input req_valid, input req_amount, output req_ready);
endinterface

// File: rtl/coin_pulse_timer.sv
// coin_pulse_timer: loadable down-counter; o_expire flags the last cycle (count == 1)
// of a loaded interval.
module coin_pulse_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_expire = (r_cnt == W'(1));
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out as timed 10/5 coin ejector pulses,
// tracks coin stock and reports the unpaid remainder.
module change_dispenser
    import coin_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int INIT_STOCK10 = 10,
    parameter int INIT_STOCK5  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    change_dispenser_if.slave    bus,
    input  logic                 i_refill10,
    input  logic                 i_refill5,
    output logic                 o_coin10,
    output logic                 o_coin5,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [AMT_W-1:0]     o_short_amt,
    output logic [7:0]           o_stock10,
    output logic [7:0]           o_stock5
);
    state_e           r_state;
    logic [AMT_W-1:0] r_owed;
    logic [AMT_W-1:0] r_short;
    logic [2:0]       r_rem;
    logic             r_sel10;
    logic [7:0]       r_stock10;
    logic [7:0]       r_stock5;

    logic             w_pick10;
    logic             w_pick5;
    logic             w_accept;
    logic             w_expire;
    logic             w_load;
    logic [15:0]      w_load_val;
    logic [2:0]       w_rem;

    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
    assign w_rem      = 3'(bus.req_amount % COIN5);
    assign w_pick10   = (r_state == ST_SELECT) && (r_owed >= COIN10) && (r_stock10 != 8'd0);
    assign w_pick5    = (r_state == ST_SELECT) && !w_pick10 && (r_owed >= COIN5) && (r_stock5 != 8'd0);
    assign w_load     = w_pick10 || w_pick5 || ((r_state == ST_PULSE) && w_expire);
    assign w_load_val = (r_state == ST_PULSE) ? 16'(GAP_CYCLES) : 16'(PULSE_CYCLES);

    coin_pulse_timer #(.W(16)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owed  <= '0;
            r_rem   <= '0;
            r_short <= '0;
            r_sel10 <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_owed  <= bus.req_amount - AMT_W'(w_rem);
                    r_rem   <= w_rem;
                    r_state <= ST_SELECT;
                end
                ST_SELECT: begin
                    r_sel10 <= w_pick10;
                    if (w_pick10 || w_pick5) begin
                        r_owed  <= r_owed - (w_pick10 ? COIN10 : COIN5);
                        r_state <= ST_PULSE;
                    end else begin
                        r_short <= r_owed + AMT_W'(r_rem);
                        r_state <= ST_DONE;
                    end
                end
                ST_PULSE: if (w_expire) r_state <= ST_GAP;
                ST_GAP:   if (w_expire) r_state <= ST_SELECT;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stock10 <= 8'(INIT_STOCK10);
            r_stock5  <= 8'(INIT_STOCK5);
        end else begin
            r_stock10 <= stock_next(r_stock10, i_refill10, w_pick10);
            r_stock5  <= stock_next(r_stock5, i_refill5, w_pick5);
        end
    end

    // Ejector lines decode only registered state, so reset drops them at once.
    assign o_coin10      = (r_state == ST_PULSE) && r_sel10;
    assign o_coin5       = (r_state == ST_PULSE) && !r_sel10;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign bus.req_ready = (r_state == ST_IDLE);
    assign o_short_amt   = r_short;
    assign o_stock10     = r_stock10;
    assign o_stock5      = r_stock5;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vectors with hand-computed coin sequences, timing,
// remainders and stock levels for change_dispenser at default parameters.
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_refill10 = 1'b0;
    logic       i_refill5 = 1'b0;
    logic       o_coin10, o_coin5, o_busy, o_done;
    logic [7:0] o_short_amt, o_stock10, o_stock5;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] seq;
    int done_k, hi10, hi5, ovl, ready_k1, s10_k2, short_got, done_seen;

    change_dispenser_if bus ();

    change_dispenser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .i_refill10  (i_refill10),
        .i_refill5   (i_refill5),
        .o_coin10    (o_coin10),
        .o_coin5     (o_coin5),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_short_amt (o_short_amt),
        .o_stock10   (o_stock10),
        .o_stock5    (o_stock5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill10_pulse();
        i_refill10 = 1'b1;
        tick();
        i_refill10 = 1'b0;
    endtask

    // Issue a request and follow it to done; seq records coin order (1=10, 2=5).
    task automatic run(input logic [7:0] amt, input logic r10_at_select);
        logic p10, p5;
        p10 = 1'b0; p5 = 1'b0;
        seq = '0; done_k = 0; hi10 = 0; hi5 = 0; ovl = 0; short_got = -1;
        bus.req_valid  = 1'b1;
        bus.req_amount = amt;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (o_coin10 && !p10) seq = {seq[27:0], 4'h1};
            if (o_coin5 && !p5)   seq = {seq[27:0], 4'h2};
            hi10 += int'(o_coin10);
            hi5  += int'(o_coin5);
            if (o_coin10 && o_coin5) ovl++;
            p10 = o_coin10;
            p5  = o_coin5;
            if (k == 1) ready_k1 = int'(bus.req_ready);
            if (k == 2) s10_k2 = int'(o_stock10);
            i_refill10 = (k == 1) && r10_at_select;
            if (o_done) begin
                done_k    = k;
                short_got = int'(o_short_amt);
                break;
            end
            tick();
        end
        i_refill10 = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_amount = 8'd0;
        #12;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_coin10", o_coin10, 0);
        chk("rst_coin5", o_coin5, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_short", o_short_amt, 0);
        chk("rst_stock10", o_stock10, 10);
        chk("rst_stock5", o_stock5, 10);
        rst_n = 1'b1;
        tick();

        run(8'd35, 1'b0);
        chk("r35_seq", seq, 32'h1112);
        chk("r35_done_at", done_k, 30);
        chk("r35_short", short_got, 0);
        chk("r35_hi10", hi10, 12);
        chk("r35_hi5", hi5, 4);
        chk("r35_overlap", ovl, 0);
        chk("r35_ready_busy", ready_k1, 0);
        chk("r35_stock_dec_pulse1", s10_k2, 9);
        chk("r35_stock10", o_stock10, 7);
        chk("r35_stock5", o_stock5, 9);
        tick();
        chk("r35_ready_after", bus.req_ready, 1);
        chk("r35_done_1cyc", o_done, 0);
        chk("r35_short_held", o_short_amt, 0);

        run(8'd23, 1'b0);
        chk("r23_seq", seq, 32'h11);
        chk("r23_done_at", done_k, 16);
        chk("r23_short", short_got, 3);
        chk("r23_stock10", o_stock10, 5);
        tick();

        run(8'd4, 1'b0);
        chk("r4_seq", seq, 32'h0);
        chk("r4_done_at", done_k, 2);
        chk("r4_short", short_got, 4);
        tick();

        run(8'd50, 1'b0);
        chk("r50_seq", seq, 32'h11111);
        chk("r50_done_at", done_k, 37);
        chk("r50_stock10", o_stock10, 0);
        tick();

        run(8'd20, 1'b0);
        chk("r20a_seq", seq, 32'h2222);
        chk("r20a_done_at", done_k, 30);
        chk("r20a_short", short_got, 0);
        chk("r20a_stock5", o_stock5, 5);
        tick();

        run(8'd20, 1'b0);
        chk("r20b_seq", seq, 32'h2222);
        chk("r20b_stock5", o_stock5, 1);
        tick();

        refill10_pulse();
        chk("refill10", o_stock10, 1);

        run(8'd40, 1'b0);
        chk("r40_seq", seq, 32'h12);
        chk("r40_done_at", done_k, 16);
        chk("r40_short", short_got, 25);
        chk("r40_stock10", o_stock10, 0);
        chk("r40_stock5", o_stock5, 0);
        tick();

        run(8'd15, 1'b0);
        chk("r15_empty_seq", seq, 32'h0);
        chk("r15_empty_done_at", done_k, 2);
        chk("r15_empty_short", short_got, 15);
        tick();

        refill10_pulse();
        refill10_pulse();
        chk("refill10_x2", o_stock10, 2);

        run(8'd10, 1'b1);
        chk("same_cycle_pulse1", s10_k2, 2);
        chk("same_cycle_seq", seq, 32'h1);
        chk("same_cycle_done_at", done_k, 9);
        chk("same_cycle_stock10", o_stock10, 2);
        tick();

        i_refill5 = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        i_refill5 = 1'b0;
        chk("refill5_sat", o_stock5, 255);
        i_refill5 = 1'b1;
        tick();
        i_refill5 = 1'b0;
        chk("refill5_at_255", o_stock5, 255);

        bus.req_valid  = 1'b1;
        bus.req_amount = 8'd10;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("mid_pulse_coin10", o_coin10, 1);
        chk("mid_pulse_stock10", o_stock10, 1);
        rst_n = 1'b0;
        #1;
        chk("async_coin10", o_coin10, 0);
        chk("async_busy", o_busy, 0);
        chk("async_stock10", o_stock10, 10);
        chk("async_stock5", o_stock5, 255 - 245);
        chk("async_short", o_short_amt, 0);
        #2;
        rst_n = 1'b1;
        chk("post_rst_ready", bus.req_ready, 1);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            done_seen += int'(o_done) + int'(o_coin10) + int'(o_coin5);
        end
        chk("post_rst_quiet", done_seen, 0);
        chk("post_rst_idle", o_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-return engine for the coin vending path: the accumulator side credits 5- and 10-unit coins, and this block pays credit back out as physical coins. It accepts a change amount over a valid/ready handshake. It ejects 10- and 5-unit coins as timed pulses for the mechanical ejector, tracks on-board coin stock, and reports any amount it could not pay.

## Interface
Parameters:
- PULSE_CYCLES, 4: cycles an ejector line is held high per coin (≥1)
- GAP_CYCLES, 2: low cycles after each coin pulse (≥1)
- INIT_STOCK10, 10: 10-coin stock after reset
- INIT_STOCK5, 10: 5-coin stock after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  change request present
- req_ready  out  1  block can accept a request
- req_amount  in  8  change owed, unsigned
- refill10  in  1  one-cycle pulse: one 10-coin added to stock
- refill5  in  1  one-cycle pulse: one 5-coin added to stock
- coin10  out  1  10-coin ejector drive
- coin5  out  1  5-coin ejector drive
- busy  out  1  request in progress
- done  out  1  one-cycle pulse at end of request
- short_amt  out  8  unpaid amount, valid while done=1, held until next done
- stock10  out  8  current 10-coin stock
- stock5  out  8  current 5-coin stock

## Operation
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: req_ready=1. A request is accepted on a rising edge with req_valid&&req_ready. Capture owed = req_amount − (req_amount mod 5) and rem = req_amount mod 5. Go to SELECT.
- SELECT, first matching rule wins:
  - owed≥10 && stock10>0: pick 10, stock10−1, owed−10, go to PULSE.
  - owed≥5 && stock5>0: pick 5, stock5−1, owed−5, go to PULSE.
  - otherwise: go to DONE.
  - Two 5-coins substitute for a 10 automatically when stock10=0.
- PULSE: the selected line is high for exactly PULSE_CYCLES cycles, then go to GAP.
- GAP: both lines low for GAP_CYCLES cycles, then go to SELECT.
- DONE: done=1 for one cycle, short_amt = owed + rem, then go to IDLE.
- busy=1 in every state except IDLE.
- Stock is 8-bit and saturates at 255 on refill.
  - A refill and a dispense of the same denomination in the same cycle leave that stock unchanged.
  - Refills are accepted in every state.
- coin10 and coin5 are never high together. Both are decoded from registered state only, so they are glitch-free.
- Reset values:
  - state IDLE; req_ready=1 (combinational from IDLE)
  - coin10=coin5=busy=done=0
  - short_amt=0
  - stock10=INIT_STOCK10, stock5=INIT_STOCK5
  - owed=rem=0

## Timing
- Request accepted at edge T. SELECT occupies cycle T+1.
- Each coin costs 1+PULSE_CYCLES+GAP_CYCLES cycles (SELECT+PULSE+GAP).
- The final SELECT is followed by DONE, then IDLE; req_ready is high again one cycle after done.
- Zero-coin request (amount 0–4): done is high in cycle T+2.
- With defaults, each coin takes 7 cycles. Amount 20 with stock: done at T+2+2·7 = T+16.
- The stock decrement is visible on stock10/stock5 in the first PULSE cycle.
- req_valid is ignored while busy. Requests are not queued.
- Reset asserted mid-operation:
  - ejector lines drop immediately;
  - the pending request is discarded with no done;
  - stock reverts to INIT values.

## Structure
- Shared package coin_pkg:
  - COIN5=5 and COIN10=10 denomination constants
  - state enum for this block
  - AMT_W=8
- Sub-module coin_pulse_timer:
  - loadable down-counter with a load value input;
  - asserts expire when the count reaches 1;
  - used for both PULSE and GAP timing.

## Test plan
- Reset, then request 35 with default stock → pulses 10,10,10,5; short_amt=0; done at T+30; stock10=7, stock5=9.
- Request 23 → pulses 10,10; short_amt=3; no extra pulse for the remainder.
- Stock10=0, request 20 → four 5-pulses; stock5 decreases by 4; short_amt=0.
- Stock10=1, stock5=1, request 40 → pulses 10,5; short_amt=25.
- refill10 in the same cycle as a 10-coin dispense → stock10 unchanged. refill5 at stock5=255 → stays 255.
- rst_n pulled low in the middle of a PULSE → coin lines go low asynchronously, no done, req_ready=1 after release.
